// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle RV64I control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: ALU operation codes, major opcodes, FSM state encoding,
// ALU operand-select encodings and the opcode-class type used by alu_decoder.
package cpu_defs;

   // ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;  // supported by the ALU, never emitted here

   // Major opcodes (instruction bits [6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // funct values used by the decoder
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [2:0] F3_DW   = 3'b011;   // ld / sd width
   localparam logic [2:0] F3_BEQ  = 3'b000;

   // ALU input1 select
   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_REG   = 2'd1;
   localparam logic [1:0] SRC_A_OLDPC = 2'd2;

   // ALU input2 select
   localparam logic [1:0] SRC_B_REG  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_EXEC_R    = 4'd2,
      ST_EXEC_I    = 4'd3,
      ST_WB_ALU    = 4'd4,
      ST_MEM_ADDR  = 4'd5,
      ST_MEM_READ  = 4'd6,
      ST_WB_MEM    = 4'd7,
      ST_MEM_WRITE = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_ILLEGAL   = 4'd10
   } state_e;

   // Opcode class handed to the ALU decoder
   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_R    = 2'd1,
      CLS_I    = 2'd2
   } op_class_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps opcode class + funct3/funct7 to an ALU operation and a legality flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   op_class_i     opcode class (CLS_R / CLS_I / CLS_NONE)
//   funct3_i       instruction bits [14:12]
//   funct7_i       instruction bits [31:25] (ignored for CLS_I)
//   alu_control_o  ALU operation code
//   legal_o        1 when the class/funct combination is supported
module alu_decoder
   import cpu_defs::*;
(
   input  logic [1:0] op_class_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [3:0] alu_control_o,
   output logic       legal_o
);

   logic f3_ok;
   logic sub_sel;

   always_comb begin
      f3_ok         = 1'b1;
      alu_control_o = ALU_ADD;
      case (funct3_i)
         3'b000:  alu_control_o = ALU_ADD;
         3'b111:  alu_control_o = ALU_AND;
         3'b110:  alu_control_o = ALU_OR;
         3'b010:  alu_control_o = ALU_SLT;
         default: f3_ok = 1'b0;
      endcase

      // funct7=0100000 selects sub only for register-register ops
      sub_sel = (op_class_i == CLS_R) && (funct7_i == F7_ALT);
      if (sub_sel) begin
         alu_control_o = ALU_SUB;
      end

      case (op_class_i)
         CLS_R:   legal_o = ((funct7_i == F7_BASE) && f3_ok) ||
                            (sub_sel && (funct3_i == 3'b000));
         CLS_I:   legal_o = f3_ok;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV64I sequential core, driving ALU and datapath strobes.
// Latency (mem_ready=1 on first request): R/I 4 cycles, ld 5, sd 4, beq 3.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; a watchdog traps to ILLEGAL.
//
// Ports: clk, reset (async, active-high); opcode/funct3/funct7 from the IR; zero from ALU;
//   mem_ready from memory; ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write,
//   mem_to_reg, alu_src_a, alu_src_b, alu_control to the datapath; illegal_instr and
//   bus_error sticky traps. With PERF_COUNTERS_EN defined, cycle_count and instret_count
//   (64-bit) are added.
module multicycle_control
   import cpu_defs::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_control,
   output logic       illegal_instr,
   output logic       bus_error
`ifdef PERF_COUNTERS_EN
   ,
   output logic [63:0] cycle_count,
   output logic [63:0] instret_count
`endif
);

   state_e      state_q, state_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic        illegal_q, illegal_d;
   logic        bus_err_q, bus_err_d;

   op_class_e   op_class;
   logic [3:0]  dec_alu;
   logic        dec_legal;
   logic        wait_state;
   logic        timeout;

   assign op_class = (opcode == OP_R)   ? CLS_R :
                     (opcode == OP_IMM) ? CLS_I : CLS_NONE;

   alu_decoder u_alu_decoder (
      .op_class_i    (op_class),
      .funct3_i      (funct3),
      .funct7_i      (funct7),
      .alu_control_o (dec_alu),
      .legal_o       (dec_legal)
   );

   assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                       (state_q == ST_MEM_WRITE);

   // Fires on the wait cycle that brings the counter up to TIMEOUT_CYCLES;
   // a cycle with mem_ready high is never a timeout, so memory wins a tie.
   assign timeout = wait_state && (TIMEOUT_CYCLES != 0) && !mem_ready &&
                    (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;

      case (state_q)
         ST_FETCH: begin
            if (mem_ready)    state_d = ST_DECODE;
            else if (timeout) state_d = ST_ILLEGAL;
         end
         ST_DECODE: begin
            case (opcode)
               OP_R:      state_d = dec_legal ? ST_EXEC_R : ST_ILLEGAL;
               OP_IMM:    state_d = dec_legal ? ST_EXEC_I : ST_ILLEGAL;
               OP_LOAD,
               OP_STORE:  state_d = (funct3 == F3_DW) ? ST_MEM_ADDR : ST_ILLEGAL;
               OP_BRANCH: state_d = (funct3 == F3_BEQ) ? ST_BRANCH : ST_ILLEGAL;
               default:   state_d = ST_ILLEGAL;
            endcase
            if (state_d == ST_ILLEGAL) illegal_d = 1'b1;
         end
         ST_EXEC_R,
         ST_EXEC_I:   state_d = ST_WB_ALU;
         ST_WB_ALU:   state_d = ST_FETCH;
         ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ: begin
            if (mem_ready)    state_d = ST_WB_MEM;
            else if (timeout) state_d = ST_ILLEGAL;
         end
         ST_WB_MEM:   state_d = ST_FETCH;
         ST_MEM_WRITE: begin
            if (mem_ready)    state_d = ST_FETCH;
            else if (timeout) state_d = ST_ILLEGAL;
         end
         ST_BRANCH:   state_d = ST_FETCH;
         ST_ILLEGAL:  state_d = ST_ILLEGAL;
         default:     state_d = ST_ILLEGAL;
      endcase

      if (timeout) bus_err_d = 1'b1;

      // Counter restarts on every state entry and only runs while waiting
      if (!wait_state || (state_d != state_q)) wait_cnt_d = '0;
      else if (!mem_ready)                     wait_cnt_d = wait_cnt_q + 32'd1;
      else                                     wait_cnt_d = wait_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Output decode. Reset forces state_q to FETCH asynchronously, so only the
   // mem_ready-qualified FETCH strobes need explicit gating with reset.
   always_comb begin
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = SRC_A_PC;
      alu_src_b   = SRC_B_REG;
      alu_control = ALU_AND;

      case (state_q)
         ST_FETCH: begin
            mem_read    = 1'b1;
            alu_src_b   = SRC_B_FOUR;
            alu_control = ALU_ADD;
            ir_write    = mem_ready && !reset;
            pc_write    = mem_ready && !reset;
         end
         ST_DECODE: begin
            alu_src_a   = SRC_A_OLDPC;
            alu_src_b   = SRC_B_IMM;
            alu_control = ALU_ADD;
         end
         ST_EXEC_R: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_REG;
            alu_control = dec_alu;
         end
         ST_EXEC_I: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_IMM;
            alu_control = dec_alu;
         end
         ST_WB_ALU: reg_write = 1'b1;
         ST_MEM_ADDR: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_IMM;
            alu_control = ALU_ADD;
         end
         ST_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         ST_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_REG;
            alu_control = ALU_SUB;
            pc_src      = 1'b1;
            pc_write    = zero;
         end
         default: ;
      endcase
   end

   assign illegal_instr = illegal_q;
   assign bus_error     = bus_err_q;

`ifdef PERF_COUNTERS_EN
   logic [63:0] cycle_cnt_q;
   logic [63:0] instret_cnt_q;
   logic        retire;

   assign retire = (state_q == ST_WB_ALU) || (state_q == ST_WB_MEM) ||
                   (state_q == ST_BRANCH) ||
                   ((state_q == ST_MEM_WRITE) && mem_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else if (state_q != ST_ILLEGAL) begin
         cycle_cnt_q <= cycle_cnt_q + 64'd1;
         if (retire) instret_cnt_q <= instret_cnt_q + 64'd1;
      end
   end

   assign cycle_count   = cycle_cnt_q;
   assign instret_count = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (TIMEOUT_CYCLES=4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// Observed vector: {ir_write,pc_write,pc_src,iord,mem_read,mem_write,reg_write,mem_to_reg,
//                   alu_src_a,alu_src_b,alu_control,illegal_instr,bus_error}
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'b0;
   logic [2:0] funct3 = 3'b0;
   logic [6:0] funct7 = 7'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       ir_write, pc_write, pc_src, iord, mem_read, mem_write;
   logic       reg_write, mem_to_reg, illegal_instr, bus_error;
   logic [1:0] alu_src_a, alu_src_b;
   logic [3:0] alu_control;
`ifdef PERF_COUNTERS_EN
   logic [63:0] cycle_count, instret_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7       (funct7),
      .zero         (zero),
      .mem_ready    (mem_ready),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .iord         (iord),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .mem_to_reg   (mem_to_reg),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_control  (alu_control),
      .illegal_instr(illegal_instr),
      .bus_error    (bus_error)
`ifdef PERF_COUNTERS_EN
      ,
      .cycle_count  (cycle_count),
      .instret_count(instret_count)
`endif
   );

   logic [17:0] obs;
   assign obs = {ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write, mem_to_reg,
                 alu_src_a, alu_src_b, alu_control, illegal_instr, bus_error};

   // Expected output vectors, written out by hand per state
   localparam logic [17:0] E_FETCH_W = {8'b0000_1000, 2'd0, 2'd1, 4'b0010, 2'b00};
   localparam logic [17:0] E_FETCH_G = {8'b1100_1000, 2'd0, 2'd1, 4'b0010, 2'b00};
   localparam logic [17:0] E_DECODE  = {8'b0000_0000, 2'd2, 2'd2, 4'b0010, 2'b00};
   localparam logic [17:0] E_WB_ALU  = {8'b0000_0010, 2'd0, 2'd0, 4'b0000, 2'b00};
   localparam logic [17:0] E_MADDR   = {8'b0000_0000, 2'd1, 2'd2, 4'b0010, 2'b00};
   localparam logic [17:0] E_MEM_RD  = {8'b0001_1000, 2'd0, 2'd0, 4'b0000, 2'b00};
   localparam logic [17:0] E_WB_MEM  = {8'b0000_0011, 2'd0, 2'd0, 4'b0000, 2'b00};
   localparam logic [17:0] E_MEM_WR  = {8'b0001_0100, 2'd0, 2'd0, 4'b0000, 2'b00};
   localparam logic [17:0] E_BR_T    = {8'b0110_0000, 2'd1, 2'd0, 4'b0110, 2'b00};
   localparam logic [17:0] E_BR_N    = {8'b0010_0000, 2'd1, 2'd0, 4'b0110, 2'b00};
   localparam logic [17:0] E_ILL     = {8'b0000_0000, 2'd0, 2'd0, 4'b0000, 2'b10};
   localparam logic [17:0] E_BUSERR  = {8'b0000_0000, 2'd0, 2'd0, 4'b0000, 2'b01};

   function automatic logic [17:0] e_exec_r(input logic [3:0] alu);
      return {8'b0000_0000, 2'd1, 2'd0, alu, 2'b00};
   endfunction

   function automatic logic [17:0] e_exec_i(input logic [3:0] alu);
      return {8'b0000_0000, 2'd1, 2'd2, alu, 2'b00};
   endfunction

   task automatic check(input string tag, input logic [17:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: apply mem_ready, check outputs, advance to next falling edge
   task automatic cyc(input logic mr, input string tag, input logic [17:0] exp);
      mem_ready = mr;
      #1;
      check(tag, exp);
      @(negedge clk);
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode = op;
      funct3 = f3;
      funct7 = f7;
   endtask

   // Reset with mem_ready high: FETCH strobes must still be masked
   task automatic do_reset(input string tag);
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      check(tag, E_FETCH_W);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset("reset_state");

      // add x3,x1,x2
      set_instr(7'b0110011, 3'b000, 7'b0000000);
      cyc(1, "add_fetch", E_FETCH_G);
      cyc(1, "add_decode", E_DECODE);
      cyc(1, "add_exec", e_exec_r(4'b0010));
      cyc(1, "add_wb", E_WB_ALU);
      cyc(0, "add_back_fetch", E_FETCH_W);

      // sub
      set_instr(7'b0110011, 3'b000, 7'b0100000);
      cyc(1, "sub_fetch", E_FETCH_G);
      cyc(1, "sub_decode", E_DECODE);
      cyc(1, "sub_exec", e_exec_r(4'b0110));
      cyc(1, "sub_wb", E_WB_ALU);

      // or
      set_instr(7'b0110011, 3'b110, 7'b0000000);
      cyc(1, "or_fetch", E_FETCH_G);
      cyc(1, "or_decode", E_DECODE);
      cyc(1, "or_exec", e_exec_r(4'b0001));
      cyc(1, "or_wb", E_WB_ALU);

      // slti: funct7 bits are ignored for immediates
      set_instr(7'b0010011, 3'b010, 7'b0100000);
      cyc(1, "slti_fetch", E_FETCH_G);
      cyc(1, "slti_decode", E_DECODE);
      cyc(1, "slti_exec", e_exec_i(4'b0111));
      cyc(1, "slti_wb", E_WB_ALU);

      // andi
      set_instr(7'b0010011, 3'b111, 7'b0000000);
      cyc(1, "andi_fetch", E_FETCH_G);
      cyc(1, "andi_decode", E_DECODE);
      cyc(1, "andi_exec", e_exec_i(4'b0000));
      cyc(1, "andi_wb", E_WB_ALU);

      // ld with three wait cycles in MEM_READ: 8 cycles total
      set_instr(7'b0000011, 3'b011, 7'b0000000);
      cyc(1, "ld_fetch", E_FETCH_G);
      cyc(1, "ld_decode", E_DECODE);
      cyc(1, "ld_addr", E_MADDR);
      cyc(0, "ld_rd_w1", E_MEM_RD);
      cyc(0, "ld_rd_w2", E_MEM_RD);
      cyc(0, "ld_rd_w3", E_MEM_RD);
      cyc(1, "ld_rd_go", E_MEM_RD);
      cyc(1, "ld_wb", E_WB_MEM);
      cyc(0, "ld_back_fetch", E_FETCH_W);

      // sd
      set_instr(7'b0100011, 3'b011, 7'b0000000);
      cyc(1, "sd_fetch", E_FETCH_G);
      cyc(1, "sd_decode", E_DECODE);
      cyc(1, "sd_addr", E_MADDR);
      cyc(1, "sd_write", E_MEM_WR);
      cyc(0, "sd_back_fetch", E_FETCH_W);

      // beq taken
      set_instr(7'b1100011, 3'b000, 7'b0000000);
      zero = 1'b1;
      cyc(1, "beq_t_fetch", E_FETCH_G);
      cyc(1, "beq_t_decode", E_DECODE);
      cyc(1, "beq_t_branch", E_BR_T);
      cyc(0, "beq_t_back_fetch", E_FETCH_W);

      // beq not taken
      zero = 1'b0;
      cyc(1, "beq_n_fetch", E_FETCH_G);
      cyc(1, "beq_n_decode", E_DECODE);
      cyc(1, "beq_n_branch", E_BR_N);
      cyc(0, "beq_n_back_fetch", E_FETCH_W);

      // lui traps and stays trapped with strobes low
      set_instr(7'b0110111, 3'b000, 7'b0000000);
      cyc(1, "lui_fetch", E_FETCH_G);
      cyc(1, "lui_decode", E_DECODE);
      cyc(1, "lui_illegal", E_ILL);
      cyc(1, "lui_sticky1", E_ILL);
      cyc(0, "lui_sticky2", E_ILL);
      do_reset("lui_reset_clears");

      // R-type funct7=0100000 with funct3=111 is not a legal op
      set_instr(7'b0110011, 3'b111, 7'b0100000);
      cyc(1, "badr_fetch", E_FETCH_G);
      cyc(1, "badr_decode", E_DECODE);
      cyc(1, "badr_illegal", E_ILL);
      do_reset("badr_reset");

      // lw (funct3=010) is not supported
      set_instr(7'b0000011, 3'b010, 7'b0000000);
      cyc(1, "lw_fetch", E_FETCH_G);
      cyc(1, "lw_decode", E_DECODE);
      cyc(1, "lw_illegal", E_ILL);
      do_reset("lw_reset");

      // Watchdog: four wait cycles in FETCH, then bus error
      set_instr(7'b0110011, 3'b000, 7'b0000000);
      cyc(0, "wd_w1", E_FETCH_W);
      cyc(0, "wd_w2", E_FETCH_W);
      cyc(0, "wd_w3", E_FETCH_W);
      cyc(0, "wd_w4", E_FETCH_W);
      cyc(0, "wd_buserr", E_BUSERR);
      cyc(1, "wd_buserr_sticky", E_BUSERR);
      do_reset("wd_reset_clears");

      // Watchdog: memory answering after three waits is a normal transition
      cyc(0, "wd_ok_w1", E_FETCH_W);
      cyc(0, "wd_ok_w2", E_FETCH_W);
      cyc(0, "wd_ok_w3", E_FETCH_W);
      cyc(1, "wd_ok_go", E_FETCH_G);
      cyc(1, "wd_ok_decode", E_DECODE);

      // Reset asserted mid-MEM_WRITE drops mem_write without a clock edge
      cyc(1, "rst_mid_exec", e_exec_r(4'b0010));
      cyc(1, "rst_mid_wb", E_WB_ALU);
      set_instr(7'b0100011, 3'b011, 7'b0000000);
      cyc(1, "rst_mid_fetch", E_FETCH_G);
      cyc(1, "rst_mid_decode", E_DECODE);
      cyc(1, "rst_mid_addr", E_MADDR);
      mem_ready = 1'b0;
      #1;
      check("rst_mid_memwr", E_MEM_WR);
      #1;
      reset = 1'b1;
      #1;
      check("rst_async_drop", E_FETCH_W);
      mem_ready = 1'b1;
      #1;
      check("rst_async_masked", E_FETCH_W);
      @(negedge clk);
      reset = 1'b0;
      cyc(1, "rst_restart_fetch", E_FETCH_G);
      cyc(1, "rst_restart_decode", E_DECODE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV64I sequential core.
- Sits directly upstream of the 64-bit ALU. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives alu_control, the ALU operand selects and all datapath/memory strobes.
- Consumes the ALU zero flag for beq.
- Supports add, sub, and, or, slt, addi, andi, ori, slti, ld, sd and beq. Anything else traps.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles to wait for mem_ready in any wait state. 0 disables the watchdog.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- funct7  in  7  instruction register bits [31:25].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = memory data register.
- alu_src_a  out  2  ALU input1 select: 0 = PC, 1 = regA, 2 = oldPC.
- alu_src_b  out  2  ALU input2 select: 0 = regB, 1 = constant 4, 2 = immediate.
- alu_control  out  4  ALU operation code.
- illegal_instr  out  1  sticky illegal-instruction trap.
- bus_error  out  1  sticky memory-timeout trap.

Behaviour:
- Reset is asynchronous and active-high on port reset; the clock is clk. Reset forces state to FETCH and clears the wait counter and both sticky flags.
- Outputs are decoded combinationally from state. During reset every output is 0 except mem_read=1, alu_src_b=1 and alu_control=ADD (the FETCH decode). Strobes of an interrupted access drop immediately on reset.
- ALU codes emitted: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111. NOR=1100 is never emitted.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=1, ADD. ir_write and pc_write (pc_src=0) assert only in the cycle mem_ready=1 (Mealy); the FSM then moves to DECODE. Otherwise it holds.
- DECODE: src_a=2, src_b=2, ADD, which stores the branch target in ALUOut. Next state by opcode/funct:
  - 0110011 with funct7=0000000 and funct3 in {000,111,110,010}, or funct7=0100000 and funct3=000 -> EXEC_R.
  - 0010011 with funct3 in {000,111,110,010} -> EXEC_I.
  - 0000011 or 0100011 with funct3=011 -> MEM_ADDR.
  - 1100011 with funct3=000 -> BRANCH.
  - Anything else -> ILLEGAL.
- EXEC_R: src_a=1, src_b=0, alu_control from the funct decode; next WB_ALU.
- EXEC_I: src_a=1, src_b=2, alu_control from funct3 decode (funct7 ignored); next WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0; next FETCH.
- MEM_ADDR: src_a=1, src_b=2, ADD; next MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: mem_read=1, iord=1; moves to WB_MEM on mem_ready.
- WB_MEM: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WRITE: mem_write=1, iord=1; moves to FETCH on mem_ready.
- BRANCH: src_a=1, src_b=0, SUB, pc_src=1, pc_write=zero; next FETCH.
- ILLEGAL: illegal_instr=1; all strobes 0; stays here until reset.
- Latency with mem_ready=1 on first request: R/I 4 cycles, ld 5, sd 4, beq 3.
- Watchdog applies in FETCH, MEM_READ and MEM_WRITE:
  - The counter clears on state entry and increments each cycle mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to ILLEGAL with bus_error=1 and illegal_instr=0.
  - mem_ready in the same cycle as the timeout wins: normal transition.
- Strobes never assert outside the listed states. mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: PERF_COUNTERS_EN.
- When defined: adds outputs cycle_count[63:0] and instret_count[63:0].
  - cycle_count increments every cycle outside reset.
  - instret_count increments on exit from WB_ALU, WB_MEM, MEM_WRITE (with mem_ready) and BRANCH.
  - Both wrap at 2^64, clear on reset, and freeze in ILLEGAL.
- When undefined: the ports and logic are absent.

Decomposition:
- Shared package/header cpu_defs holds:
  - ALU operation codes.
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH).
  - The FSM state encoding.
  - alu_src_a/b select encodings.
- Sub-module alu_decoder: combinational mapping of opcode-class/funct3/funct7 to alu_control plus a legal flag. It is reused by the FSM for DECODE legality and EXEC op select.

Test Plan:
- add x3,x1,x2 with mem_ready=1 always -> states FETCH,DECODE,EXEC_R,WB_ALU; alu_control=0010 in EXEC_R; reg_write=1 only in cycle 4.
- sub (funct7=0100000, funct3=000) -> alu_control=0110. slti (opcode 0010011, funct3=010) -> alu_control=0111 with src_b=2.
- ld with mem_ready held low 3 cycles in MEM_READ -> mem_read=1, iord=1 for 4 cycles, then WB_MEM with mem_to_reg=1; total 8 cycles.
- beq with zero=1 in BRANCH -> pc_write=1, pc_src=1, alu_control=0110. Repeat with zero=0 -> pc_write=0, next state FETCH.
- opcode 0110111 (lui) -> ILLEGAL in the cycle after DECODE; illegal_instr=1 sticky; all strobes 0 until reset.
- TIMEOUT_CYCLES=4 with mem_ready stuck 0 in FETCH -> bus_error=1 after 4 wait cycles. Assert reset mid-MEM_WRITE -> mem_write drops asynchronously and the FSM restarts in FETCH.
